// File: rtl/dp_pkg.sv
// Shared FP32 constants and types for the dot-product accumulator.
// Imported by dp_acc and its fp32_add datapath.
package dp_pkg;

   localparam int EXP_W      = 8;
   localparam int MAN_W      = 23;
   localparam int BIAS       = 127;
   localparam int DP_LAT_DEF = 4;

   localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
   localparam logic [31:0] FP32_PINF = 32'h7F80_0000;
   localparam logic [31:0] FP32_NINF = 32'hFF80_0000;

   typedef enum logic {
      EMPTY,
      ACCUM
   } acc_state_t;

endpackage

// File: rtl/fp32_add.sv
// Combinational FP32 adder: align, add/sub, LZC normalize, RNE round.
// Subnormals in and out are flushed to signed zero.
module fp32_add
   import dp_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   assign sa = a[31];
   assign sb = b[31];
   assign ea = a[30:23];
   assign eb = b[30:23];
   assign fa = a[22:0];
   assign fb = b[22:0];

   assign a_nan  = (ea == 8'hFF) && (fa != '0);
   assign b_nan  = (eb == 8'hFF) && (fb != '0);
   assign a_inf  = (ea == 8'hFF) && (fa == '0);
   assign b_inf  = (eb == 8'hFF) && (fb == '0);
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);

   logic             s_big;
   logic [EXP_W-1:0] e_big, d;
   logic [26:0]      m_big, m_small, m_al;
   logic [27:0]      w;
   logic [4:0]       lz;
   logic [26:0]      n;
   logic [9:0]       e_n, e_r;
   logic [24:0]      m_r;
   logic [22:0]      f_r;
   logic             inc;

   always_comb begin
      // Operand with the larger magnitude drives sign and exponent
      if ({eb, fb} > {ea, fa}) begin
         s_big   = sb;
         e_big   = eb;
         d       = eb - ea;
         m_big   = {1'b1, fb, 3'b000};
         m_small = {1'b1, fa, 3'b000};
      end else begin
         s_big   = sa;
         e_big   = ea;
         d       = ea - eb;
         m_big   = {1'b1, fa, 3'b000};
         m_small = {1'b1, fb, 3'b000};
      end

      if (d >= 8'd27)
         m_al = 27'd1;
      else
         m_al = (m_small >> d)
              | {26'd0, |(m_small << (5'd27 - d[4:0]))};

      if (sa ^ sb)
         w = {1'b0, m_big} - {1'b0, m_al};
      else
         w = {1'b0, m_big} + {1'b0, m_al};

      lz = 5'd27;
      for (int i = 0; i < 27; i++)
         if (w[i]) lz = 5'(26 - i);

      if (w[27]) begin
         n   = w[27:1] | {26'd0, w[0]};
         e_n = {2'b00, e_big} + 10'd1;
      end else begin
         n   = w[26:0] << lz;
         e_n = {2'b00, e_big} - {5'd0, lz};
      end

      inc = n[2] & ((|n[1:0]) | n[3]);
      m_r = {1'b0, n[26:3]} + {24'd0, inc};
      if (m_r[24]) begin
         e_r = e_n + 10'd1;
         f_r = m_r[23:1];
      end else begin
         e_r = e_n;
         f_r = m_r[22:0];
      end

      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
         y = FP32_QNAN;
      else if (a_inf)
         y = sa ? FP32_NINF : FP32_PINF;
      else if (b_inf)
         y = sb ? FP32_NINF : FP32_PINF;
      else if (a_zero && b_zero)
         y = {sa & sb, 31'd0};
      else if (a_zero)
         y = b;
      else if (b_zero)
         y = a;
      else if (w == '0)
         y = 32'd0;
      else if (e_r[9] || (e_r == '0))
         y = {s_big, 31'd0};
      else if (e_r >= 10'd255)
         y = s_big ? FP32_NINF : FP32_PINF;
      else
         y = {s_big, e_r[7:0], f_r};
   end

endmodule

// File: rtl/dp_acc.sv
// Accumulates FP32 dot-product groups into per-vector sums, with
// issue flags delayed to line up with the dp_pipe result.
module dp_acc
   import dp_pkg::*;
#(
   parameter int DP_LAT = DP_LAT_DEF,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   input  logic             issue_last,
   input  logic             flush,
   input  logic [31:0]      dp_result,
   output logic             sum_valid,
   output logic [31:0]      sum,
   output logic [CNT_W-1:0] sum_count,
   output logic             cnt_ovf
);

   logic [DP_LAT-1:0] vq, lq;
   logic              r_valid, r_last;
   acc_state_t        state;
   logic [31:0]       acc, add_y, ftz_y, nxt_acc;
   logic [CNT_W-1:0]  cnt, nxt_cnt;
   logic              sat;

   assign r_valid = vq[DP_LAT-1];
   assign r_last  = lq[DP_LAT-1];

   fp32_add u_add (
      .a (acc),
      .b (dp_result),
      .y (add_y)
   );

   // First group of a vector is taken as-is apart from FTZ
   assign ftz_y = (dp_result[30:23] == '0)
                ? {dp_result[31], 31'd0} : dp_result;

   assign sat     = &cnt;
   assign nxt_acc = (state == EMPTY) ? ftz_y : add_y;
   assign nxt_cnt = (state == EMPTY) ? CNT_W'(1)
                  : (sat ? cnt : cnt + CNT_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vq        <= '0;
         lq        <= '0;
         state     <= EMPTY;
         acc       <= '0;
         cnt       <= '0;
         cnt_ovf   <= 1'b0;
         sum_valid <= 1'b0;
         sum       <= '0;
         sum_count <= '0;
      end else if (flush) begin
         vq        <= '0;
         lq        <= '0;
         state     <= EMPTY;
         acc       <= '0;
         cnt       <= '0;
         cnt_ovf   <= 1'b0;
         sum_valid <= 1'b0;
      end else begin
         vq[0] <= issue_valid;
         lq[0] <= issue_valid & issue_last;
         for (int i = 1; i < DP_LAT; i++) begin
            vq[i] <= vq[i-1];
            lq[i] <= lq[i-1];
         end
         sum_valid <= 1'b0;
         if (r_valid) begin
            acc <= nxt_acc;
            cnt <= nxt_cnt;
            if (state == ACCUM && sat)
               cnt_ovf <= 1'b1;
            if (r_last) begin
               state     <= EMPTY;
               sum_valid <= 1'b1;
               sum       <= nxt_acc;
               sum_count <= nxt_cnt;
            end else begin
               state <= ACCUM;
            end
         end
      end
   end

endmodule

// File: tb/tb_dp_acc.sv
// Directed bench for dp_acc: table of vectors plus flush,
// back-to-back and reset sequences.
module tb_dp_acc;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid, issue_last, flush;
   logic [31:0] dp_result;
   logic        sum_valid;
   logic [31:0] sum;
   logic [15:0] sum_count;
   logic        cnt_ovf;

   dp_acc #(.DP_LAT(LAT), .CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_last  (issue_last),
      .flush       (flush),
      .dp_result   (dp_result),
      .sum_valid   (sum_valid),
      .sum         (sum),
      .sum_count   (sum_count),
      .cnt_ovf     (cnt_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               n;
      logic [3:0][31:0] v;
      logic [31:0]      exp_sum;
      int               exp_cnt;
      string            name;
   } vec_t;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   logic [31:0] sched [0:1023];
   logic [31:0] p_sum [$];
   int          p_cnt [$];
   int          p_cyc [$];
   vec_t        vecs [7];

   function automatic vec_t mk(int n, logic [31:0] a, logic [31:0] b,
                               logic [31:0] c, logic [31:0] d,
                               logic [31:0] e, int k, string nm);
      vec_t r;
      r.n       = n;
      r.v[0]    = a;
      r.v[1]    = b;
      r.v[2]    = c;
      r.v[3]    = d;
      r.exp_sum = e;
      r.exp_cnt = k;
      r.name    = nm;
      return r;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // One cycle: drive just after negedge, observe 1 ns after posedge
   task automatic tick(logic v, logic l, logic [31:0] val, logic fl);
      issue_valid = v;
      issue_last  = l;
      flush       = fl;
      if (v) sched[cyc+LAT] = val;
      dp_result = sched[cyc];
      @(posedge clk);
      #1;
      if (sum_valid) begin
         p_sum.push_back(sum);
         p_cnt.push_back(int'(sum_count));
         p_cyc.push_back(cyc + 1);
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic clr();
      p_sum.delete();
      p_cnt.delete();
      p_cyc.delete();
   endtask

   task automatic idle(int k);
      for (int i = 0; i < k; i++) tick(1'b0, 1'b0, 32'd0, 1'b0);
   endtask

   initial begin
      int iss;
      for (int i = 0; i < 1024; i++) sched[i] = 32'hDEAD_BEEF;
      vecs[0] = mk(4, 32'h3F800000, 32'h40000000, 32'h40400000,
                   32'h40800000, 32'h41200000, 4, "sum1234");
      vecs[1] = mk(1, 32'hC0A00000, 0, 0, 0, 32'hC0A00000, 1, "single");
      vecs[2] = mk(2, 32'h7F800000, 32'hFF800000, 0, 0,
                   32'h7FC00000, 2, "inf_ninf");
      vecs[3] = mk(2, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 0,
                   32'h7F800000, 2, "ovf_inf");
      vecs[4] = mk(2, 32'h3F800000, 32'hBF800000, 0, 0,
                   32'h00000000, 2, "cancel");
      vecs[5] = mk(2, 32'h3F800000, 32'h33800000, 0, 0,
                   32'h3F800000, 2, "rne_tie_even");
      vecs[6] = mk(2, 32'h3F800001, 32'h33800000, 0, 0,
                   32'h3F800002, 2, "rne_tie_up");

      rst = 1'b0;
      issue_valid = 1'b0;
      issue_last  = 1'b0;
      flush       = 1'b0;
      dp_result   = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(sum_valid), 64'd0);
      chk("rst_sum",   64'(sum),       64'd0);
      chk("rst_count", 64'(sum_count), 64'd0);
      chk("rst_ovf",   64'(cnt_ovf),   64'd0);
      @(negedge clk);
      rst = 1'b1;
      idle(2);

      for (int k = 0; k < 7; k++) begin
         clr();
         iss = 0;
         for (int g = 0; g < vecs[k].n; g++) begin
            iss = cyc;
            tick(1'b1, g == vecs[k].n - 1, vecs[k].v[g], 1'b0);
         end
         idle(LAT + 3);
         chk({vecs[k].name, "_pulses"}, 64'(p_sum.size()), 64'd1);
         chk({vecs[k].name, "_sum"},
             64'(p_sum.size() > 0 ? p_sum[0] : 32'hxxxxxxxx),
             64'(vecs[k].exp_sum));
         chk({vecs[k].name, "_count"},
             64'(p_cnt.size() > 0 ? p_cnt[0] : -1), 64'(vecs[k].exp_cnt));
         chk({vecs[k].name, "_latency"},
             64'(p_cyc.size() > 0 ? p_cyc[0] - iss : -1), 64'(LAT + 1));
      end

      chk("hold_sum",   64'(sum),       64'h3F800002);
      chk("hold_count", 64'(sum_count), 64'd2);

      // Back-to-back vectors with no idle gap
      clr();
      iss = cyc;
      tick(1'b1, 1'b1, 32'h3F800000, 1'b0);
      tick(1'b1, 1'b0, 32'h40000000, 1'b0);
      tick(1'b1, 1'b1, 32'h40000000, 1'b0);
      idle(LAT + 3);
      chk("b2b_pulses", 64'(p_sum.size()), 64'd2);
      if (p_sum.size() == 2) begin
         chk("b2b_sum0", 64'(p_sum[0]), 64'h3F800000);
         chk("b2b_cnt0", 64'(p_cnt[0]), 64'd1);
         chk("b2b_lat0", 64'(p_cyc[0] - iss), 64'(LAT + 1));
         chk("b2b_sum1", 64'(p_sum[1]), 64'h40800000);
         chk("b2b_cnt1", 64'(p_cnt[1]), 64'd2);
         chk("b2b_lat1", 64'(p_cyc[1] - iss - 2), 64'(LAT + 1));
      end

      // Flush with groups in flight; issue during flush is dropped
      clr();
      tick(1'b1, 1'b0, 32'h40400000, 1'b0);
      tick(1'b1, 1'b0, 32'h40400000, 1'b0);
      tick(1'b1, 1'b0, 32'h40400000, 1'b0);
      idle(1);
      tick(1'b1, 1'b1, 32'h40E00000, 1'b1);
      iss = cyc;
      tick(1'b1, 1'b1, 32'h3F800000, 1'b0);
      idle(LAT + 3);
      chk("flush_pulses", 64'(p_sum.size()), 64'd1);
      chk("flush_sum",
          64'(p_sum.size() > 0 ? p_sum[0] : 32'hxxxxxxxx), 64'h3F800000);
      chk("flush_count",
          64'(p_cnt.size() > 0 ? p_cnt[0] : -1), 64'd1);
      chk("flush_latency",
          64'(p_cyc.size() > 0 ? p_cyc[0] - iss : -1), 64'(LAT + 1));
      chk("flush_ovf", 64'(cnt_ovf), 64'd0);

      // Asynchronous reset with a vector in flight
      clr();
      tick(1'b1, 1'b0, 32'h3F800000, 1'b0);
      tick(1'b1, 1'b1, 32'h40000000, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(sum_valid), 64'd0);
      chk("mid_rst_sum",   64'(sum),       64'd0);
      chk("mid_rst_count", 64'(sum_count), 64'd0);
      chk("mid_rst_ovf",   64'(cnt_ovf),   64'd0);
      @(negedge clk);
      rst = 1'b1;
      idle(LAT + 3);
      chk("mid_rst_pulses", 64'(p_sum.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dp_acc.md
Name: dp_acc

Overview:
- Downstream consumer of dp_pipe. Accumulates successive FP32 4-lane dot-product results into one FP32 sum, which allows vectors longer than 4 elements.
- Issue-side valid/last flags travel through an internal delay line of DP_LAT stages, so they line up with dp_pipe's result, which carries no valid of its own.
- Emits the sum for each vector as a one-cycle pulse. No backpressure, because dp_pipe cannot stall.

Parameters:
- DP_LAT, 4, dp_pipe latency in cycles from operand presentation to a valid result (range 1..8).
- CNT_W, 16, width of the per-vector group counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- issue_valid  input  1  high in the cycle x1..y4 are presented to dp_pipe.
- issue_last  input  1  qualifies issue_valid; marks the final 4-element group of a vector.
- flush  input  1  synchronous; discards partial sum and all in-flight flags.
- dp_result  input  32  FP32 result from dp_pipe.
- sum_valid  output  1  one-cycle pulse; sum is valid.
- sum  output  32  FP32 accumulated vector sum.
- sum_count  output  CNT_W  number of groups accumulated into sum.
- cnt_ovf  output  1  sticky; group counter saturated; cleared by reset or flush.

Behaviour:
- Reset (rst low, asynchronous): delay line cleared, acc=0, state=EMPTY, sum_valid=0, sum=0, sum_count=0, cnt_ovf=0.
- Delay line: DP_LAT-stage shift register of {valid,last}. issue_last is ignored when issue_valid=0. Stage-DP_LAT output is (r_valid, r_last), aligned with dp_result.
- FSM states:
  - EMPTY: on r_valid, acc<=dp_result with FTZ applied (bit-exact otherwise, no add), cnt<=1, go to ACCUM.
  - ACCUM: on r_valid, acc<=fp32_add(acc, dp_result), cnt<=cnt+1. cnt saturates at all-ones and sets cnt_ovf.
  - r_last with r_valid in either state: the registered output, one cycle after the r_valid edge, is sum_valid=1, sum=the new acc value, sum_count=new cnt. State returns to EMPTY.
  - A group arriving in the very next cycle starts a fresh vector; back-to-back vectors need no gap.
- Latency: issue of last group to sum_valid = DP_LAT+1 cycles.
- sum and sum_count hold their last value while sum_valid=0.
- fp32_add rules:
  - Rounding: IEEE-754 round-to-nearest-even.
  - Subnormal inputs and results flush to signed zero.
  - Overflow gives ±Inf.
  - Any NaN operand, or Inf + (-Inf), gives canonical 0x7FC00000.
  - Exact cancellation gives +0. (-0)+(-0) gives -0.
- flush:
  - Clears the delay line, acc, cnt and cnt_ovf, and forces EMPTY. Flush wins over a simultaneous r_valid.
  - sum_valid is 0 in the following cycle; sum and sum_count are unchanged.
  - issue_valid in the same cycle as flush is also dropped.
- Reset mid-vector: the partial sum is lost and no sum_valid is produced.
- FP16 (half_mode) is not supported in this revision; the block is FP32 only.

Decomposition:
- Shared package dp_pkg:
  - FP32 field widths: EXP_W=8, MAN_W=23, BIAS=127.
  - Constants FP32_QNAN=32'h7FC00000, FP32_PINF=32'h7F800000, FP32_NINF=32'h FF800000.
  - DP_LAT default.
- One sub-module, fp32_add: combinational, handling align, add/sub, normalize (LZC), RNE round and specials.
- dp_acc contains the delay line, FSM, counter and output registers.

Test Plan:
- Four groups giving 1.0, 2.0, 3.0, 4.0 (0x3F800000, 0x40000000, 0x40400000, 0x40800000), last on the fourth → after last issue + 5 cycles: one pulse, sum=0x41200000, sum_count=4.
- Single-group vector, dp_result=0xC0A00000, issue_valid and last together → sum=0xC0A00000 bit-exact, sum_count=1, latency exactly 5 cycles.
- Back-to-back vectors with no gap, {1.0, last} then {2.0, 2.0, last} → two pulses, sum=0x3F800000 then 0x40800000, counts 1 then 2.
- Specials, each as a separate 2-group vector:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
  - 0x3F800000 + 0xBF800000 → 0x00000000.
- Rounding: 0x3F800000 + 0x33800000 (tie) → 0x3F800000; 0x3F800001 + 0x33800000 → 0x3F800002.
- flush and reset:
  - flush 2 cycles after issuing 3 non-last groups, then new vector {1.0, last} → single pulse sum=0x3F800000, sum_count=1.
  - rst asserted mid-vector → all outputs 0 immediately and no pulse.
